// File: rtl/instr_fetch_if.sv
// Bundle of fetch-unit signals: instruction-memory request/response,
// execute-stage redirect and the decode-side instruction handoff.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, 2-credit in-flight address queue,
// 2-entry instruction buffer and redirect squashing of stale responses.
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0] pc;
  logic [63:0] aq_addr [2];
  logic [1:0]  aq_cnt;
  logic [31:0] ib_instr [2];
  logic [63:0] ib_pc [2];
  logic [1:0]  ib_cnt;
  logic [1:0]  drop_cnt;

  logic        rsp_fire;
  logic        rsp_keep;
  logic        id_fire;
  logic        req_fire;
  logic [2:0]  credits_used;
  logic [1:0]  aq_wr_pos;
  logic [1:0]  ib_wr_pos;

  always_comb begin
    rsp_fire = bus.imem_rsp_valid && (aq_cnt != 2'd0);
    rsp_keep = rsp_fire && (drop_cnt == 2'd0);
    id_fire  = (ib_cnt != 2'd0) && bus.id_ready && !bus.redirect_valid;
    // The slot freed by this cycle's decode pop is reusable at once, which
    // is what lets a 1-cycle memory sustain one instruction per cycle.
    credits_used = {1'b0, aq_cnt} + {1'b0, ib_cnt} - {2'b00, id_fire};
    bus.imem_req_valid = !reset && !bus.redirect_valid && (credits_used < 3'd2);
    bus.imem_req_addr  = pc;
    req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    aq_wr_pos = aq_cnt - {1'b0, rsp_fire};
    ib_wr_pos = ib_cnt - {1'b0, id_fire};
    bus.id_valid = (ib_cnt != 2'd0);
    bus.id_instr = bus.id_valid ? ib_instr[0] : NOP;
    bus.id_pc    = bus.id_valid ? ib_pc[0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      aq_cnt   <= '0;
      ib_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (rsp_fire) aq_addr[0] <= aq_addr[1];
      if (bus.redirect_valid) begin
        // Every request still in flight after this cycle's response is stale.
        pc       <= {bus.redirect_pc[63:2], 2'b00};
        ib_cnt   <= '0;
        aq_cnt   <= aq_wr_pos;
        drop_cnt <= aq_wr_pos;
      end else begin
        if (req_fire) begin
          pc                    <= pc + 64'd4;
          aq_addr[aq_wr_pos[0]] <= pc;
        end
        aq_cnt <= aq_wr_pos + {1'b0, req_fire};
        if (rsp_fire && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
        if (id_fire) begin
          ib_instr[0] <= ib_instr[1];
          ib_pc[0]    <= ib_pc[1];
        end
        if (rsp_keep) begin
          ib_instr[ib_wr_pos[0]] <= bus.imem_rsp_data;
          ib_pc[ib_wr_pos[0]]    <= aq_addr[0];
        end
        ib_cnt <= ib_wr_pos + {1'b0, rsp_keep};
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order memory model plus a
// program-order reference of request and decode PCs.
module tb_instr_fetch;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if bus();
  instr_fetch #(.RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned lat_extra = 0;

  logic [63:0] mq_addr[$];
  int unsigned mq_due[$];
  logic [63:0] exp_req_pc;
  logic [63:0] exp_id_pc;

  logic        s_req_valid, s_id_valid;
  logic [63:0] s_req_addr, s_id_pc;
  logic [31:0] s_id_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic drive(input bit rdy, input bit idr, input bit redir,
                       input logic [63:0] rpc, input bit rsp_ok, input bit spur);
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (mq_addr.size() != 0) begin
      if (rsp_ok && mq_due[0] <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq_addr[0]);
      end
    end else if (spur) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = JUNK;
    end
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_id_valid  = bus.id_valid;
    s_id_pc     = bus.id_pc;
    s_id_instr  = bus.id_instr;
  endtask

  task automatic tick();
    bit req_fire, rsp_fire, id_fire;
    req_fire = s_req_valid && bus.imem_req_ready;
    rsp_fire = bus.imem_rsp_valid && (mq_addr.size() != 0);
    id_fire  = s_id_valid && bus.id_ready && !bus.redirect_valid;
    @(posedge clk);
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
      exp_req_pc = RESET_PC;
      exp_id_pc  = RESET_PC;
    end else begin
      if (rsp_fire) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (bus.redirect_valid) begin
        exp_req_pc = {bus.redirect_pc[63:2], 2'b00};
        exp_id_pc  = exp_req_pc;
      end else begin
        if (req_fire) begin
          mq_addr.push_back(s_req_addr);
          mq_due.push_back(cyc + 1 + lat_extra);
          exp_req_pc = exp_req_pc + 64'd4;
        end
        if (id_fire) exp_id_pc = exp_id_pc + 64'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, '0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, 1, 64'h1234, 1, 1);
    checks++;
    if (s_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", s_req_valid); end
    tick();
    drive(1, 1, 1, 64'h1234, 1, 1);
    checks++;
    if (s_id_valid !== 1'b0 || s_id_instr !== NOP || s_id_pc !== 64'h0) begin
      failures++;
      $display("FAIL reset_id_outputs got=%b/%h/%h want=0/%h/0", s_id_valid, s_id_instr, s_id_pc, NOP);
    end
    tick();
    reset = 1'b0;
    drive(1, 1, 0, '0, 1, 1);
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_first_req got=%b/%h want=1/%h", s_req_valid, s_req_addr, RESET_PC);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, '0, 1, 0);
      if (s_id_valid) begin
        checks++;
        if (s_id_pc !== RESET_PC || s_id_instr !== mem_word(RESET_PC)) begin
          failures++;
          $display("FAIL reset_first_id got=%h/%h want=%h/%h", s_id_pc, s_id_instr, RESET_PC, mem_word(RESET_PC));
        end
        tick();
        return;
      end
      tick();
    end
    checks++; failures++;
    $display("FAIL reset_first_id timeout got=none want=%h", RESET_PC);
  endtask

  task automatic test_stream();
    do_reset();
    lat_extra = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1, 1, 0, '0, 1, 0);
      checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC + 64'(4 * i)) begin
        failures++;
        $display("FAIL stream_req[%0d] got=%b/%h want=1/%h", i, s_req_valid, s_req_addr, RESET_PC + 64'(4 * i));
      end
      if (i >= 2) begin
        checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== RESET_PC + 64'(4 * (i - 2)) ||
            s_id_instr !== mem_word(RESET_PC + 64'(4 * (i - 2)))) begin
          failures++;
          $display("FAIL stream_id[%0d] got=%b/%h/%h want=1/%h", i, s_id_valid, s_id_pc, s_id_instr,
                   RESET_PC + 64'(4 * (i - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held_pc;
    logic [31:0] held_instr;
    held_pc = '0;
    held_instr = '0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, '0, 1, 0);
      if (i == 0) begin
        held_pc = s_id_pc;
        held_instr = s_id_instr;
        checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== exp_id_pc) begin
          failures++;
          $display("FAIL stall_head got=%b/%h want=1/%h", s_id_valid, s_id_pc, exp_id_pc);
        end
      end else begin
        checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== held_pc || s_id_instr !== held_instr) begin
          failures++;
          $display("FAIL stall_stable[%0d] got=%b/%h/%h want=1/%h/%h", i, s_id_valid, s_id_pc, s_id_instr,
                   held_pc, held_instr);
        end
      end
      if (i == 5) begin
        checks++;
        if (s_req_valid !== 1'b0 || mq_addr.size() != 0) begin
          failures++;
          $display("FAIL stall_credits got=req%b/out%0d want=req0/out0", s_req_valid, mq_addr.size());
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, '0, 1, 0);
      checks++;
      if (i < 2) begin
        if (s_id_valid !== 1'b1 || s_id_pc !== exp_id_pc || s_id_instr !== mem_word(exp_id_pc)) begin
          failures++;
          $display("FAIL drain[%0d] got=%b/%h/%h want=1/%h", i, s_id_valid, s_id_pc, s_id_instr, exp_id_pc);
        end
      end else if (s_id_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_count got=id_valid%b want=0", s_id_valid);
      end
      tick();
    end
  endtask

  task automatic wait_first_id(input string name, input logic [63:0] want);
    for (int i = 0; i < 30; i++) begin
      drive(1, 1, 0, '0, 1, 0);
      if (s_id_valid) begin
        checks++;
        if (s_id_pc !== want || s_id_instr !== mem_word(want)) begin
          failures++;
          $display("FAIL %s got=%h/%h want=%h/%h", name, s_id_pc, s_id_instr, want, mem_word(want));
        end
        tick();
        return;
      end
      tick();
    end
    checks++; failures++;
    $display("FAIL %s timeout got=none want=%h", name, want);
  endtask

  task automatic test_redirect_outstanding();
    bit seen;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin drive(1, 0, 0, '0, 0, 0); tick(); end
    checks++;
    if (mq_addr.size() != 2) begin failures++; $display("FAIL redir_setup got=%0d want=2", mq_addr.size()); end
    drive(1, 1, 1, 64'h1003, 0, 0);
    checks++;
    if (s_req_valid !== 1'b0) begin failures++; $display("FAIL redir_no_req got=%b want=0", s_req_valid); end
    tick();
    for (int i = 0; i < 20 && !seen; i++) begin
      drive(1, 0, 0, '0, 1, 0);
      if (s_req_valid) begin
        seen = 1'b1;
        checks++;
        if (s_req_addr !== 64'h1000) begin failures++; $display("FAIL redir_addr got=%h want=1000", s_req_addr); end
      end
      tick();
    end
    if (!seen) begin checks++; failures++; $display("FAIL redir_addr timeout got=none want=1000"); end
    wait_first_id("redir_first_id", 64'h1000);
  endtask

  task automatic test_redirect_with_rsp();
    do_reset();
    for (int i = 0; i < 2; i++) begin drive(1, 0, 0, '0, 0, 0); tick(); end
    drive(1, 1, 1, 64'h2000, 1, 0);
    checks++;
    if (s_req_valid !== 1'b0) begin failures++; $display("FAIL redir_rsp_no_req got=%b want=0", s_req_valid); end
    tick();
    drive(1, 1, 0, '0, 0, 0);
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 64'h2000) begin
      failures++;
      $display("FAIL redir_rsp_req got=%b/%h want=1/2000", s_req_valid, s_req_addr);
    end
    tick();
    wait_first_id("redir_rsp_first_id", 64'h2000);
  endtask

  task automatic test_wrap();
    int unsigned nreq;
    do_reset();
    nreq = 0;
    drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, '0, 1, 0);
      if (s_req_valid && nreq < 2) begin
        checks++;
        if (s_req_addr !== (nreq == 0 ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h0)) begin
          failures++;
          $display("FAIL wrap_req[%0d] got=%h", nreq, s_req_addr);
        end
        nreq++;
      end
      tick();
    end
    wait_first_id("wrap_id0", 64'hFFFF_FFFF_FFFF_FFFC);
    wait_first_id("wrap_id1", 64'h0);
  endtask

  task automatic test_back_to_back();
    logic [63:0] tgt;
    tgt = '0;
    for (int i = 0; i < 5; i++) begin drive(1, 1, 0, '0, 1, 0); tick(); end
    for (int i = 0; i < 3; i++) begin
      tgt = {$urandom, $urandom};
      drive(1, 1, 1, tgt, 1, 0);
      checks++;
      if (s_req_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_req[%0d] got=%b want=0", i, s_req_valid); end
      tick();
    end
    tgt = {tgt[63:2], 2'b00};
    wait_first_id("b2b_id0", tgt);
    wait_first_id("b2b_id1", tgt + 64'd4);
    wait_first_id("b2b_id2", tgt + 64'd8);
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 5; i++) begin drive(1, 1, 0, '0, 1, 0); tick(); end
    for (int i = 0; i < 2; i++) begin drive(1, 0, 0, '0, 0, 0); tick(); end
    reset = 1'b1;
    drive(1, 1, 1, 64'h5550, 1, 0);
    tick();
    reset = 1'b0;
    drive(1, 1, 0, '0, 1, 1);
    checks++;
    if (s_id_valid !== 1'b0 || s_id_instr !== NOP || s_id_pc !== 64'h0) begin
      failures++;
      $display("FAIL midreset_id got=%b/%h/%h want=0/%h/0", s_id_valid, s_id_instr, s_id_pc, NOP);
    end
    checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL midreset_req got=%b/%h want=1/%h", s_req_valid, s_req_addr, RESET_PC);
    end
    tick();
    wait_first_id("midreset_first_id", RESET_PC);
  endtask

  task automatic test_random();
    bit rdy, idr, redir, prev_hold;
    logic [63:0] prev_pc;
    logic [31:0] prev_instr;
    int unsigned pops;
    do_reset();
    prev_hold = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      idr   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 19) == 0);
      lat_extra = $urandom_range(0, 2);
      drive(rdy, idr, redir, {$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
      checks++;
      if (redir && s_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL rnd_redir_req[%0d] got=%b want=0", i, s_req_valid);
      end
      if (s_req_valid) begin
        checks++;
        if (s_req_addr !== exp_req_pc) begin
          failures++;
          $display("FAIL rnd_req_addr[%0d] got=%h want=%h", i, s_req_addr, exp_req_pc);
        end
      end
      checks++;
      if (mq_addr.size() > 2) begin failures++; $display("FAIL rnd_outstanding[%0d] got=%0d want<=2", i, mq_addr.size()); end
      if (prev_hold) begin
        checks++;
        if (s_id_valid !== 1'b1 || s_id_pc !== prev_pc || s_id_instr !== prev_instr) begin
          failures++;
          $display("FAIL rnd_hold[%0d] got=%b/%h/%h want=1/%h/%h", i, s_id_valid, s_id_pc, s_id_instr, prev_pc, prev_instr);
        end
      end
      if (s_id_valid && idr && !redir) begin
        pops++;
        checks++;
        if (s_id_pc !== exp_id_pc || s_id_instr !== mem_word(exp_id_pc)) begin
          failures++;
          $display("FAIL rnd_id[%0d] got=%h/%h want=%h/%h", i, s_id_pc, s_id_instr, exp_id_pc, mem_word(exp_id_pc));
        end
      end
      prev_hold  = s_id_valid && !idr && !redir;
      prev_pc    = s_id_pc;
      prev_instr = s_id_instr;
      tick();
    end
    lat_extra = 0;
    checks++;
    if (pops < 200) begin failures++; $display("FAIL rnd_progress got=%0d want>=200", pops); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    exp_req_pc = RESET_PC;
    exp_id_pc  = RESET_PC;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_with_rsp();
    test_wrap();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
